bram_2048x8: RTL and testbench

// - True dual-port synchronous block RAM, 2048 words x 8 bits, with per-bit write mask on each port.
// - Leaf primitive of the SRAM-bank wrappers: wrappers tile it by depth/width and drive each port

---
 rtl/bram_2048x8_if.sv | 30 +++
 rtl/bram_2048x8.sv | 98 +++++++++
 tb/tb_bram_2048x8.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bram_2048x8_if.sv
// -----------------------------------------------------------------------------
// bram_2048x8_if
// One access port of the 2048x8 true-dual-port block RAM.
//
// Signals (slave = RAM side):
//   ce   in   1       port enable; when low the port is idle and q holds
//   a    in   ADDR_W  word address
//   d    in   DATA_W  write data
//   we   in   1       write enable, qualified by ce
//   wem  in   DATA_W  per-bit write mask, 1 = write that bit
//   q    out  DATA_W  registered read data, valid one cycle after the edge
//
// Protocol: there is no handshake. The RAM accepts a request on every rising
// edge where ce=1. The request is {a, we, d, wem}. A read returns q on the
// following cycle. Backpressure does not exist.
// -----------------------------------------------------------------------------
interface bram_2048x8_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
);
   logic              ce;
   logic [ADDR_W-1:0] a;
   logic [DATA_W-1:0] d;
   logic              we;
   logic [DATA_W-1:0] wem;
   logic [DATA_W-1:0] q;

   modport master (output ce, a, d, we, wem, input q);
   modport slave  (input ce, a, d, we, wem, output q);
endinterface

// File: rtl/bram_2048x8.sv
// -----------------------------------------------------------------------------
// bram_2048x8
// True dual-port synchronous block RAM with 2**ADDR_W words of DATA_W bits and a
// per-bit write mask on each port. Both ports are symmetric and share CLK.
//
// Ports:
//   CLK    in   1       single rising-edge clock
//   RST    in   1       synchronous active-high reset. It clears q on both
//                       ports and blocks writes. Memory contents are kept.
//   port0  bram_2048x8_if.slave   access port 0
//   port1  bram_2048x8_if.slave   access port 1
//
// WRITE_MODE sets the same-port read-during-write result:
//   0 = WRITE_FIRST (q = merged new word)
//   1 = READ_FIRST  (q = old word)
//   2 = NO_CHANGE   (q holds)
//
// Cross-port behaviour at the same address:
//   - A read on one port returns the old word.
//   - If both ports write, the stored word is the per-bit merge. Port 1 wins
//     on bits that are set in both masks.
// -----------------------------------------------------------------------------
module bram_2048x8 #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 8,
   parameter int WRITE_MODE = 0
) (
   input logic          CLK,
   input logic          RST,
   bram_2048x8_if.slave port0,
   bram_2048x8_if.slave port1
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              wr0, wr1, collide;
   logic [DATA_W-1:0] old0, old1;
   logic [DATA_W-1:0] new0, new1;

   always_comb begin
      wr0     = port0.ce & port0.we & ~RST;
      wr1     = port1.ce & port1.we & ~RST;
      collide = wr0 & wr1 & (port0.a == port1.a);
      old0    = mem[port0.a];
      old1    = mem[port1.a];
      new0    = (old0 & ~port0.wem) | (port0.d & port0.wem);
      new1    = (old1 & ~port1.wem) | (port1.d & port1.wem);
      // Both ports write the same word. Both ports store the fully merged word.
      // Either write order then gives the same result, and port 1 wins on
      // overlapping mask bits.
      if (collide) begin
         new0 = (old0 & ~(port0.wem | port1.wem))
              | (port0.d & port0.wem & ~port1.wem)
              | (port1.d & port1.wem);
         new1 = new0;
      end
   end

   // Storage has no reset. The masked merge above happens in the same edge, so
   // a masked write adds no latency.
   always_ff @(posedge CLK) begin
      if (wr0) mem[port0.a] <= new0;
      if (wr1) mem[port1.a] <= new1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         port0.q <= '0;
      end else if (port0.ce) begin
         if (!port0.we) begin
            port0.q <= old0;
         end else begin
            case (WRITE_MODE)
               0:       port0.q <= new0;
               1:       port0.q <= old0;
               default: port0.q <= port0.q;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         port1.q <= '0;
      end else if (port1.ce) begin
         if (!port1.we) begin
            port1.q <= old1;
         end else begin
            case (WRITE_MODE)
               0:       port1.q <= new1;
               1:       port1.q <= old1;
               default: port1.q <= port1.q;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_bram_2048x8.sv
// -----------------------------------------------------------------------------
// tb_bram_2048x8
// Directed bench for bram_2048x8. Three instances (WRITE_FIRST, READ_FIRST and
// NO_CHANGE) receive identical stimulus. Instance m0 (WRITE_FIRST) is the
// primary checked instance. The other two are compared on same-port
// read-during-write.
// -----------------------------------------------------------------------------
module tb_bram_2048x8;
   logic        CLK = 1'b0;
   logic        RST;
   logic        ce0, we0, ce1, we1;
   logic [10:0] a0, a1;
   logic [7:0]  d0, wem0, d1, wem1;
   logic [7:0]  q0_m [3];
   logic [7:0]  q1_m [3];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  rq;

   always #5 CLK = ~CLK;

   bram_2048x8_if #(.ADDR_W(11), .DATA_W(8)) p0_m0 (), p1_m0 (),
                                             p0_m1 (), p1_m1 (),
                                             p0_m2 (), p1_m2 ();

   assign {p0_m0.ce, p0_m0.a, p0_m0.d, p0_m0.we, p0_m0.wem} = {ce0, a0, d0, we0, wem0};
   assign {p0_m1.ce, p0_m1.a, p0_m1.d, p0_m1.we, p0_m1.wem} = {ce0, a0, d0, we0, wem0};
   assign {p0_m2.ce, p0_m2.a, p0_m2.d, p0_m2.we, p0_m2.wem} = {ce0, a0, d0, we0, wem0};
   assign {p1_m0.ce, p1_m0.a, p1_m0.d, p1_m0.we, p1_m0.wem} = {ce1, a1, d1, we1, wem1};
   assign {p1_m1.ce, p1_m1.a, p1_m1.d, p1_m1.we, p1_m1.wem} = {ce1, a1, d1, we1, wem1};
   assign {p1_m2.ce, p1_m2.a, p1_m2.d, p1_m2.we, p1_m2.wem} = {ce1, a1, d1, we1, wem1};
   assign q0_m[0] = p0_m0.q;
   assign q0_m[1] = p0_m1.q;
   assign q0_m[2] = p0_m2.q;
   assign q1_m[0] = p1_m0.q;
   assign q1_m[1] = p1_m1.q;
   assign q1_m[2] = p1_m2.q;

   bram_2048x8 #(.ADDR_W(11), .DATA_W(8), .WRITE_MODE(0)) dut_m0 (.CLK(CLK), .RST(RST), .port0(p0_m0), .port1(p1_m0));
   bram_2048x8 #(.ADDR_W(11), .DATA_W(8), .WRITE_MODE(1)) dut_m1 (.CLK(CLK), .RST(RST), .port0(p0_m1), .port1(p1_m1));
   bram_2048x8 #(.ADDR_W(11), .DATA_W(8), .WRITE_MODE(2)) dut_m2 (.CLK(CLK), .RST(RST), .port0(p0_m2), .port1(p1_m2));

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // Advance one edge, then settle past it so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      ce0 = 1'b0; we0 = 1'b0;
      ce1 = 1'b0; we1 = 1'b0;
   endtask

   task automatic wr0(input logic [10:0] a, input logic [7:0] d, input logic [7:0] m);
      ce0 = 1'b1; we0 = 1'b1; a0 = a; d0 = d; wem0 = m;
      tick();
      ce0 = 1'b0; we0 = 1'b0;
   endtask

   task automatic rd0(input logic [10:0] a);
      ce0 = 1'b1; we0 = 1'b0; a0 = a;
      tick();
      ce0 = 1'b0;
   endtask

   task automatic rd1(input logic [10:0] a, output logic [7:0] q);
      ce1 = 1'b1; we1 = 1'b0; a1 = a;
      tick();
      q = q1_m[0];
      ce1 = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      ce0 = 1'b1; we0 = 1'b0; a0 = 11'd5; d0 = 8'h00; wem0 = 8'h00;
      ce1 = 1'b1; we1 = 1'b0; a1 = 11'd5; d1 = 8'h00; wem1 = 8'h00;
      tick();
      check_eq("reset_q0", q0_m[0], 8'h00);
      check_eq("reset_q1", q1_m[0], 8'h00);

      // Preload mem[5]. Reset must clear q without touching the memory contents.
      RST = 1'b0;
      idle();
      wr0(11'd5, 8'hA5, 8'hFF);
      check_eq("wf_q0_preload", q0_m[0], 8'hA5);
      RST = 1'b1; ce0 = 1'b1; ce1 = 1'b1; a0 = 11'd5; a1 = 11'd5;
      tick();
      check_eq("reset2_q0", q0_m[0], 8'h00);
      check_eq("reset2_q1", q1_m[0], 8'h00);
      RST = 1'b0;
      idle();
      rd1(11'd5, rq);
      check_eq("keep_mem5", rq, 8'hA5);

      // Address boundaries, write on port 0 and read on port 1.
      wr0(11'h000, 8'h3C, 8'hFF);
      rd1(11'h000, rq);
      check_eq("addr_lo", rq, 8'h3C);
      wr0(11'h7FF, 8'hC3, 8'hFF);
      rd1(11'h7FF, rq);
      check_eq("addr_hi", rq, 8'hC3);
      rd1(11'h000, rq);
      check_eq("addr_lo_kept", rq, 8'h3C);

      // Bit mask: clearing the low nibble, then an empty mask.
      wr0(11'd9, 8'hFF, 8'hFF);
      wr0(11'd9, 8'h00, 8'h0F);
      rd1(11'd9, rq);
      check_eq("mask_0f", rq, 8'hF0);
      wr0(11'd9, 8'hAA, 8'h00);
      check_eq("mask_00_q0", q0_m[0], 8'hF0);
      rd1(11'd9, rq);
      check_eq("mask_00", rq, 8'hF0);

      // Same-port read-during-write in all three modes. Q0 is first set to F0
      // so that the NO_CHANGE instance has a known value to hold.
      wr0(11'd3, 8'h11, 8'hFF);
      rd0(11'd9);
      check_eq("rd0_m2_pre", q0_m[2], 8'hF0);
      wr0(11'd3, 8'h22, 8'hFF);
      check_eq("rdw_write_first", q0_m[0], 8'h22);
      check_eq("rdw_read_first", q0_m[1], 8'h11);
      check_eq("rdw_no_change", q0_m[2], 8'hF0);

      // Cross-port: port 0 writes while port 1 reads the same address.
      wr0(11'd7, 8'h55, 8'hFF);
      ce0 = 1'b1; we0 = 1'b1; a0 = 11'd7; d0 = 8'hAA; wem0 = 8'hFF;
      ce1 = 1'b1; we1 = 1'b0; a1 = 11'd7;
      tick();
      idle();
      check_eq("xport_old", q1_m[0], 8'h55);
      rd1(11'd7, rq);
      check_eq("xport_new", rq, 8'hAA);

      // Cross-port dual write with overlapping masks. Port 1 wins the overlap:
      // (F0 & ~3C) | (0F & 3C) = C0 | 0C = CC.
      ce0 = 1'b1; we0 = 1'b1; a0 = 11'd7; d0 = 8'hF0; wem0 = 8'hFF;
      ce1 = 1'b1; we1 = 1'b1; a1 = 11'd7; d1 = 8'h0F; wem1 = 8'h3C;
      tick();
      idle();
      check_eq("dual_wf_q0", q0_m[0], 8'hCC);
      check_eq("dual_wf_q1", q1_m[0], 8'hCC);
      rd1(11'd7, rq);
      check_eq("dual_mem", rq, 8'hCC);

      // With CE1 low, Q1 holds and a stray WE1 does not write.
      rd1(11'h000, rq);
      check_eq("hold_pre", rq, 8'h3C);
      for (int i = 0; i < 3; i++) begin
         ce1 = 1'b0; we1 = 1'b1; a1 = 11'(i + 1) ^ 11'h000; d1 = 8'hFF; wem1 = 8'hFF;
         a1 = (i == 0) ? 11'h000 : 11'($urandom_range(1, 2047));
         tick();
         check_eq($sformatf("hold_q1_%0d", i), q1_m[0], 8'h3C);
      end
      idle();
      rd1(11'h000, rq);
      check_eq("hold_no_write", rq, 8'h3C);

      // Reset in the middle of a write must suppress that write.
      wr0(11'd2, 8'h5A, 8'hFF);
      RST = 1'b1; ce0 = 1'b1; we0 = 1'b1; a0 = 11'd2; d0 = 8'h00; wem0 = 8'hFF;
      tick();
      RST = 1'b0;
      idle();
      check_eq("rst_wr_q0", q0_m[0], 8'h00);
      rd1(11'd2, rq);
      check_eq("rst_wr_mem", rq, 8'h5A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
